// File: rtl/data_mem_responder_if.sv
// rtl/data_mem_responder_if.sv - data-memory request/response bundle (sign_ext present when DMEM_SIGN_EXT_EN is defined)
interface data_mem_responder_if;
    // Request side, driven by the datapath/control unit.
    logic        req;
    logic        mem_write;
    logic [1:0]  size;
    logic [63:0] address;
    logic [63:0] write_data;
`ifdef DMEM_SIGN_EXT_EN
    logic        sign_ext;
`endif

    // Response side, driven by the memory responder.
    logic [63:0] read_data;
    logic        ready;
    logic        fault;
    logic        busy;

    modport master (
`ifdef DMEM_SIGN_EXT_EN
        output sign_ext,
`endif
        output req,
        output mem_write,
        output size,
        output address,
        output write_data,
        input  read_data,
        input  ready,
        input  fault,
        input  busy
    );

    modport slave (
`ifdef DMEM_SIGN_EXT_EN
        input  sign_ext,
`endif
        input  req,
        input  mem_write,
        input  size,
        input  address,
        input  write_data,
        output read_data,
        output ready,
        output fault,
        output busy
    );
endinterface

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - fixed-latency byte-addressed little-endian data RAM responder (optional DMEM_SIGN_EXT_EN)
module data_mem_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    data_mem_responder_if.slave   bus
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t      state;
    state_t      state_n;
    logic [3:0]  count;
    logic [3:0]  count_n;
    logic        accept;
    logic        complete;

    // Request fields captured at acceptance; the live bus is ignored afterwards.
    logic        lat_write;
    logic [1:0]  lat_size;
    logic [63:0] lat_addr;
    logic [63:0] lat_wdata;
`ifdef DMEM_SIGN_EXT_EN
    logic        lat_sext;
`endif

    logic        misaligned;
    logic        out_of_range;
    logic        access_fault;
    logic [7:0]  byte_en;
    logic [ADDR_W-1:0] byte_idx [8];
    logic [63:0] load_raw;
    logic [63:0] load_word;

    logic [7:0]  mem [0:DEPTH-1];

    logic        ready_q;
    logic        fault_q;
    logic [63:0] read_data_q;

    // State register and latency counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
            count <= 4'd0;
        end else begin
            state <= state_n;
            count <= count_n;
        end
    end

    // Next-state logic: accept in IDLE, count down in BUSY, complete when the count is exhausted.
    always_comb begin
        state_n  = state;
        count_n  = count;
        accept   = 1'b0;
        complete = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.req) begin
                    accept  = 1'b1;
                    state_n = ST_BUSY;
                    count_n = 4'(LATENCY - 1);
                end
            end
            ST_BUSY: begin
                if (count != 4'd0) begin
                    count_n = count - 4'd1;
                end else begin
                    complete = 1'b1;
                    state_n  = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
                count_n = 4'd0;
            end
        endcase
    end

    // Capture the request at the accepting edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            lat_write <= 1'b0;
            lat_size  <= 2'b00;
            lat_addr  <= 64'd0;
            lat_wdata <= 64'd0;
`ifdef DMEM_SIGN_EXT_EN
            lat_sext  <= 1'b0;
`endif
        end else if (accept) begin
            lat_write <= bus.mem_write;
            lat_size  <= bus.size;
            lat_addr  <= bus.address;
            lat_wdata <= bus.write_data;
`ifdef DMEM_SIGN_EXT_EN
            lat_sext  <= bus.sign_ext;
`endif
        end
    end

    // Alignment / range checks and the per-byte lane enables for the captured size.
    always_comb begin
        misaligned = 1'b0;
        byte_en    = 8'h01;
        case (lat_size)
            2'b00: begin
                misaligned = 1'b0;
                byte_en    = 8'h01;
            end
            2'b01: begin
                misaligned = lat_addr[0];
                byte_en    = 8'h03;
            end
            2'b10: begin
                misaligned = |lat_addr[1:0];
                byte_en    = 8'h0F;
            end
            default: begin
                misaligned = |lat_addr[2:0];
                byte_en    = 8'hFF;
            end
        endcase
        out_of_range = |lat_addr[63:ADDR_W];
        access_fault = misaligned | out_of_range;
    end

    // RAM index of each byte lane; aligned in-range accesses never cross the top of memory.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            byte_idx[i] = lat_addr[ADDR_W-1:0] + ADDR_W'(i);
        end
    end

    // Little-endian assembly of the enabled lanes, zero-extended.
    always_comb begin
        load_raw = 64'd0;
        for (int i = 0; i < 8; i++) begin
            if (byte_en[i]) begin
                load_raw[8*i +: 8] = mem[byte_idx[i]];
            end
        end
    end

    // Optional sign extension of sub-doubleword loads.
    always_comb begin
        load_word = load_raw;
`ifdef DMEM_SIGN_EXT_EN
        if (lat_sext) begin
            case (lat_size)
                2'b00:   load_word = {{56{load_raw[7]}},  load_raw[7:0]};
                2'b01:   load_word = {{48{load_raw[15]}}, load_raw[15:0]};
                2'b10:   load_word = {{32{load_raw[31]}}, load_raw[31:0]};
                default: load_word = load_raw;
            endcase
        end
`endif
    end

    // Store commit happens only on the completion edge, so a reset beforehand drops the write.
    always_ff @(posedge clock) begin
        if (!reset && complete && lat_write && !access_fault) begin
            for (int i = 0; i < 8; i++) begin
                if (byte_en[i]) begin
                    mem[byte_idx[i]] <= lat_wdata[8*i +: 8];
                end
            end
        end
    end

    // Registered completion pulse, fault flag and load result.
    always_ff @(posedge clock) begin
        if (reset) begin
            ready_q     <= 1'b0;
            fault_q     <= 1'b0;
            read_data_q <= 64'd0;
        end else begin
            ready_q <= complete;
            fault_q <= complete & access_fault;
            if (complete) begin
                if (access_fault) begin
                    read_data_q <= 64'd0;
                end else if (!lat_write) begin
                    read_data_q <= load_word;
                end
            end
        end
    end

    assign bus.ready     = ready_q;
    assign bus.fault     = fault_q;
    assign bus.read_data = read_data_q;
    assign bus.busy      = (state == ST_BUSY);

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed self-checking bench for data_mem_responder (LATENCY=2, ADDR_W=10)
module tb_data_mem_responder;

    logic clock;
    logic reset;
    int   tests;
    int   fails;

    data_mem_responder_if bus ();

    data_mem_responder #(
        .ADDR_W  (10),
        .LATENCY (2)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One access: request at the next edge, then scramble the bus and wait for ready.
    task automatic access(input logic wr, input logic [1:0] sz, input logic [63:0] addr,
                          input logic [63:0] wd, input logic sx,
                          output logic [63:0] rd, output logic flt, output int lat);
        bus.req        = 1'b1;
        bus.mem_write  = wr;
        bus.size       = sz;
        bus.address    = addr;
        bus.write_data = wd;
`ifdef DMEM_SIGN_EXT_EN
        bus.sign_ext   = sx;
`else
        if (sx) bus.req = 1'b1;
`endif
        @(posedge clock); #1;
        bus.req        = 1'b0;
        bus.mem_write  = ~wr;
        bus.size       = 2'b00;
        bus.address    = 64'h48;
        bus.write_data = 64'hA5A5_A5A5_A5A5_A5A5;
        chk("busy_after_accept", 64'(bus.busy), 64'd1);
        lat = 0;
        while (!bus.ready && lat < 20) begin
            @(posedge clock); #1;
            lat++;
        end
        rd  = bus.read_data;
        flt = bus.fault;
    endtask

    logic [63:0] rd;
    logic        flt;
    int          lat;
    logic [6:0]  exp_rdy;
    logic [6:0]  exp_busy;

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        bus.req        = 1'b1;
        bus.mem_write  = 1'b1;
        bus.size       = 2'b11;
        bus.address    = 64'h30;
        bus.write_data = 64'hFFFF_FFFF_FFFF_FFFF;
`ifdef DMEM_SIGN_EXT_EN
        bus.sign_ext   = 1'b0;
`endif

        // Reset held two cycles with req high.
        for (int c = 0; c < 2; c++) begin
            @(posedge clock); #1;
            chk("rst_ready", 64'(bus.ready), 64'd0);
            chk("rst_busy",  64'(bus.busy),  64'd0);
            chk("rst_rdata", bus.read_data,  64'd0);
        end
        reset   = 1'b0;
        bus.req = 1'b0;
        @(posedge clock); #1;
        chk("post_rst_busy", 64'(bus.busy), 64'd0);

        // STUR / LDUR / LDURB
        access(1'b1, 2'b11, 64'h10, 64'h1122_3344_5566_7788, 1'b0, rd, flt, lat);
        chk("stur_lat",   64'(lat), 64'd2);
        chk("stur_fault", 64'(flt), 64'd0);
        chk("stur_rdata_kept", rd, 64'd0);
        access(1'b0, 2'b11, 64'h10, 64'd0, 1'b0, rd, flt, lat);
        chk("ldur_lat",  64'(lat), 64'd2);
        chk("ldur_data", rd, 64'h1122_3344_5566_7788);
        access(1'b0, 2'b00, 64'h13, 64'd0, 1'b0, rd, flt, lat);
        chk("ldurb_data", rd, 64'h55);

        // STURH over zeros
        access(1'b1, 2'b11, 64'h20, 64'd0, 1'b0, rd, flt, lat);
        access(1'b1, 2'b01, 64'h20, 64'h7777_6666_5555_BEEF, 1'b0, rd, flt, lat);
        chk("sturh_rdata_kept", rd, 64'h55);
        access(1'b0, 2'b11, 64'h20, 64'd0, 1'b0, rd, flt, lat);
        chk("sturh_data", rd, 64'h0000_0000_0000_BEEF);

        // STURW only touches four bytes
        access(1'b1, 2'b11, 64'h20, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, rd, flt, lat);
        access(1'b1, 2'b10, 64'h20, 64'hDEAD_DEAD_1234_5678, 1'b0, rd, flt, lat);
        access(1'b0, 2'b11, 64'h20, 64'd0, 1'b0, rd, flt, lat);
        chk("sturw_data", rd, 64'hFFFF_FFFF_1234_5678);

        // Faults
        access(1'b0, 2'b11, 64'h0C, 64'd0, 1'b0, rd, flt, lat);
        chk("mis_ld_fault", 64'(flt), 64'd1);
        chk("mis_ld_rdata", rd, 64'd0);
        chk("mis_ld_lat",   64'(lat), 64'd2);
        access(1'b1, 2'b10, 64'h12, 64'hCCCC_CCCC, 1'b0, rd, flt, lat);
        chk("mis_st_fault", 64'(flt), 64'd1);
        access(1'b0, 2'b11, 64'h10, 64'd0, 1'b0, rd, flt, lat);
        chk("mis_st_nowrite", rd, 64'h1122_3344_5566_7788);
        chk("ok_fault_low", 64'(flt), 64'd0);
        access(1'b0, 2'b01, 64'h11, 64'd0, 1'b0, rd, flt, lat);
        chk("mis_h_fault", 64'(flt), 64'd1);
        access(1'b0, 2'b00, 64'h400, 64'd0, 1'b0, rd, flt, lat);
        chk("oor_fault", 64'(flt), 64'd1);
        chk("oor_rdata", rd, 64'd0);

        // Back-to-back store -> load accepted in the ready cycle
        access(1'b1, 2'b11, 64'h30, 64'h5555_5555_5555_5555, 1'b0, rd, flt, lat);
        access(1'b0, 2'b11, 64'h30, 64'd0, 1'b0, rd, flt, lat);
        chk("b2b_lat",  64'(lat), 64'd2);
        chk("b2b_data", rd, 64'h5555_5555_5555_5555);
        @(posedge clock); #1;
        chk("pulse_ready_low", 64'(bus.ready), 64'd0);
        chk("pulse_fault_low", 64'(bus.fault), 64'd0);
        chk("pulse_busy_low",  64'(bus.busy),  64'd0);

        // req pulse during BUSY is ignored
        bus.req = 1'b1; bus.mem_write = 1'b0; bus.size = 2'b11; bus.address = 64'h10;
        @(posedge clock); #1;
        bus.req = 1'b1; bus.mem_write = 1'b1; bus.address = 64'h30;
        bus.write_data = 64'hDEAD_BEEF_DEAD_BEEF;
        @(posedge clock); #1;
        bus.req = 1'b0;
        @(posedge clock); #1;
        chk("ign_ready", 64'(bus.ready), 64'd1);
        chk("ign_data",  bus.read_data, 64'h1122_3344_5566_7788);
        @(posedge clock); #1;
        chk("ign_no_2nd_busy", 64'(bus.busy), 64'd0);
        @(posedge clock); #1;
        chk("ign_no_2nd_ready", 64'(bus.ready), 64'd0);
        access(1'b0, 2'b11, 64'h30, 64'd0, 1'b0, rd, flt, lat);
        chk("ign_no_write", rd, 64'h5555_5555_5555_5555);
        @(posedge clock); #1;

        // req held high: accepts at edges 0 and 3, ready after edges 2 and 5
        exp_rdy  = 7'b0100100;
        exp_busy = 7'b0011011;
        bus.req = 1'b1; bus.mem_write = 1'b0; bus.size = 2'b11; bus.address = 64'h10;
        for (int e = 0; e < 7; e++) begin
            @(posedge clock); #1;
            if (e == 3) bus.req = 1'b0;
            chk($sformatf("cont_ready_e%0d", e), 64'(bus.ready), 64'(exp_rdy[e]));
            chk($sformatf("cont_busy_e%0d", e),  64'(bus.busy),  64'(exp_busy[e]));
        end

        // Reset one cycle before ready drops the store
        bus.req = 1'b1; bus.mem_write = 1'b1; bus.size = 2'b11; bus.address = 64'h30;
        bus.write_data = 64'hFFFF_FFFF_FFFF_FFFF;
        @(posedge clock); #1;
        bus.req = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        chk("midrst_ready", 64'(bus.ready), 64'd0);
        chk("midrst_busy",  64'(bus.busy),  64'd0);
        chk("midrst_rdata", bus.read_data,  64'd0);
        reset = 1'b0;
        @(posedge clock); #1;
        chk("midrst_ready2", 64'(bus.ready), 64'd0);
        access(1'b0, 2'b11, 64'h30, 64'd0, 1'b0, rd, flt, lat);
        chk("midrst_old", rd, 64'h5555_5555_5555_5555);

        // Byte 0x80 load: sign-extended when the option is built and requested
        access(1'b1, 2'b00, 64'h40, 64'h80, 1'b0, rd, flt, lat);
`ifdef DMEM_SIGN_EXT_EN
        access(1'b0, 2'b00, 64'h40, 64'd0, 1'b1, rd, flt, lat);
        chk("sext_byte", rd, 64'hFFFF_FFFF_FFFF_FF80);
        access(1'b0, 2'b11, 64'h10, 64'd0, 1'b1, rd, flt, lat);
        chk("sext_dword", rd, 64'h1122_3344_5566_7788);
`else
        access(1'b0, 2'b00, 64'h40, 64'd0, 1'b0, rd, flt, lat);
        chk("zext_byte", rd, 64'h80);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
